// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Optional match counter is enabled by defining SEQ_DET_CNT_EN.
package seq_det_pkg;

    typedef enum logic {
        SD_IDLE  = 1'b0,
        SD_ARMED = 1'b1
    } sd_state_e;

    // A pattern length is usable only when it is 1..maxLen bits long.
    function automatic logic len_ok(input logic [31:0] len, input logic [31:0] maxLen);
        return (len != 32'd0) && (len <= maxLen);
    endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter with a clear that wins over a simultaneous increment.
// Only built when SEQ_DET_CNT_EN is defined.
module seq_det_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with run-time pattern, length and overlap mode.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_cnt,
    output logic               out,
    output logic               armed,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_cnt
);

    sd_state_e          r_state;
    sd_state_e          w_nextState;

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_out;
    logic               r_cfgErr;

    logic               w_lenOk;
    logic               w_load;
    logic               w_shift;
    logic [MAX_LEN-1:0] w_nextHist;
    logic [LEN_W-1:0]   w_nextFill;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;

    assign w_lenOk = len_ok(32'(cfg_len), 32'(MAX_LEN));
    assign w_load  = cfg_load && w_lenOk;

    // Any cfg_load, legal or not, drops a coincident data bit.
    assign w_shift = (r_state == SD_ARMED) && in_valid && !cfg_load;

    always_comb begin
        w_nextHist = {r_hist[MAX_LEN-2:0], in};
        w_nextFill = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : (r_fill + LEN_W'(1));
        w_mask     = ~({MAX_LEN{1'b1}} << r_len);
        w_match    = w_shift
                  && ((w_nextHist & w_mask) == (r_pattern & w_mask))
                  && (w_nextFill >= r_len);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= SD_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_load) begin
            w_nextState = SD_ARMED;
        end
    end

    // A non-overlapping match flushes history so its bits cannot start the next match.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_out     <= 1'b0;
            r_cfgErr  <= 1'b0;
        end else begin
            r_out    <= w_match;
            r_cfgErr <= cfg_load && !w_lenOk;
            if (w_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_hist    <= '0;
                r_fill    <= '0;
            end else if (w_shift) begin
                if (w_match && !r_overlap) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_nextHist;
                    r_fill <= w_nextFill;
                end
            end
        end
    end

    assign out     = r_out;
    assign armed   = (r_state == SD_ARMED);
    assign cfg_err = r_cfgErr;

`ifdef SEQ_DET_CNT_EN
    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_match),
        .i_clr (clr_cnt),
        .o_cnt (match_cnt)
    );
`else
    logic w_unusedClr;
    assign w_unusedClr = clr_cnt;
    assign match_cnt   = '0;
`endif

endmodule
